actuator_scheduler: RTL and testbench

ACTUATOR_SCHEDULER -- requirements
Module: actuator_scheduler

---
 rtl/actuator_scheduler_if.sv | 29 ++
 rtl/actuator_scheduler.sv | 158 +++++++++++++++
 tb/tb_actuator_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/actuator_scheduler_if.sv
// Request/actuator bundle for actuator_scheduler.
// slave: scheduler side; master: requesters plus actuator model side.
interface actuator_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    localparam int RW = 2 * DW + 1;

    logic [NREQ-1:0]    iReq;
    logic [NREQ*DW-1:0] iData;
    logic [NREQ-1:0]    oAck;
    logic [NREQ-1:0]    oTimeout;
    logic [RW-1:0]      oResult;
    logic               oActEn;
    logic [DW-1:0]      oActData;
    logic [RW-1:0]      iActResult;
    logic               iActComplete;
    logic               oBusy;

    modport slave (
        input  iReq, iData, iActResult, iActComplete,
        output oAck, oTimeout, oResult, oActEn, oActData, oBusy
    );

    modport master (
        output iReq, iData, iActResult, iActComplete,
        input  oAck, oTimeout, oResult, oActEn, oActData, oBusy
    );
endinterface

// File: rtl/actuator_scheduler.sv
// Round-robin scheduler sharing one actuator among NREQ requesters.
// Ports: iClk, iRst (sync, active-high), bus (slave modport: requests,
// ack/timeout pulses, result, actuator start/operand/result/complete, busy).
module actuator_scheduler #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023
) (
    input logic               iClk,
    input logic               iRst,
    actuator_scheduler_if.slave bus
);
    localparam int RW = 2 * DW + 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        RESPOND
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] tmo_q, tmo_d;
    logic [RW-1:0]   result_q, result_d;
    logic            act_en_q, act_en_d;
    logic [DW-1:0]   act_data_q, act_data_d;
    logic            busy_q, busy_d;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;
    logic [DW-1:0]   gnt_data;
    logic [CW-1:0]   cnt_inc;
    logic            cnt_hit;

    // Descending walk so the lowest offset from ptr wins the grant.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (bus.iReq[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == gnt_idx) begin
                gnt_data = bus.iData[i*DW +: DW];
            end
        end
    end

    assign cnt_inc = cnt_q + 1'b1;
    assign cnt_hit = (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        act_data_d = act_data_q;
        ack_d      = '0;
        tmo_d      = '0;
        result_d   = '0;
        act_en_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    idx_d      = gnt_idx;
                    act_data_d = gnt_data;
                    act_en_d   = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = ARM;
            end
            // Complete still high here belongs to the previous operation.
            ARM: begin
                cnt_d = cnt_inc;
                if (cnt_hit) begin
                    tmo_d[idx_q] = 1'b1;
                    state_d      = RESPOND;
                end else if (!bus.iActComplete) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (bus.iActComplete) begin
                    ack_d[idx_q] = 1'b1;
                    result_d     = bus.iActResult;
                    state_d      = RESPOND;
                end else if (cnt_hit) begin
                    tmo_d[idx_q] = 1'b1;
                    state_d      = RESPOND;
                end
            end
            RESPOND: begin
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            tmo_q      <= '0;
            result_q   <= '0;
            act_en_q   <= 1'b0;
            act_data_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            tmo_q      <= tmo_d;
            result_q   <= result_d;
            act_en_q   <= act_en_d;
            act_data_q <= act_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.oAck     = ack_q;
    assign bus.oTimeout = tmo_q;
    assign bus.oResult  = result_q;
    assign bus.oActEn   = act_en_q;
    assign bus.oActData = act_data_q;
    assign bus.oBusy    = busy_q;
endmodule

// File: tb/tb_actuator_scheduler.sv
// Scoreboard bench for actuator_scheduler with a behavioural actuator:
// complete stays high 2 cycles past a start, drops, rises act_lat later.
module tb_actuator_scheduler;
    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 8;
    localparam int RW      = 2 * DW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    actuator_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

    actuator_scheduler #(
        .NREQ(NREQ),
        .DW(DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] tmo;
        logic [RW-1:0]   res;
        logic [DW-1:0]   opnd;
        int              lat;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] en_q[$];

    int n_chk  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int en_cyc = 0;

    int act_hold  = 2;
    int act_lat   = 3;
    bit act_stuck = 1'b0;
    int act_t     = -1;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Actuator model
    initial begin
        bus.iActComplete = 1'b1;
        bus.iActResult   = '0;
        forever begin
            @(negedge clk);
            if (bus.oActEn) act_t = 0;
            else if (act_t >= 0) act_t++;
            if (act_t == act_hold) bus.iActComplete = 1'b0;
            if (act_t == act_hold + act_lat && !act_stuck) begin
                bus.iActComplete = 1'b1;
                bus.iActResult   = RW'(bus.oActData % 31);
            end
        end
    end

    task automatic step();
        logic [DW-1:0] d;
        exp_t          e;
        @(negedge clk);
        cyc++;
        if (bus.oActEn) begin
            en_cyc = cyc;
            chk("busy_en", bus.oBusy, 1);
            if (en_q.size() == 0) begin
                chk("unexp_en", bus.oActEn, 0);
            end else begin
                d = en_q.pop_front();
                chk("act_data", bus.oActData, d);
            end
        end
        if ((bus.oAck | bus.oTimeout) != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexp_resp", {bus.oAck, bus.oTimeout}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ack", bus.oAck, e.ack);
                chk("tmo", bus.oTimeout, e.tmo);
                chk("result", bus.oResult, e.res);
                chk("held_data", bus.oActData, e.opnd);
                chk("latency", cyc - en_cyc, e.lat);
            end
        end
    endtask

    task automatic expect_op(int k, logic [DW-1:0] d, bit tmo);
        exp_t e;
        en_q.push_back(d);
        e.ack  = tmo ? '0 : NREQ'(1) << k;
        e.tmo  = tmo ? NREQ'(1) << k : '0;
        e.res  = tmo ? '0 : RW'(d % 31);
        e.opnd = d;
        e.lat  = tmo ? TIMEOUT + 1 : act_lat + 3;
        exp_q.push_back(e);
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_bound", exp_q.size(), 0);
    endtask

    task automatic wait_grant(int budget);
        int n;
        n = 0;
        while (en_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("grant_bound", en_q.size(), 0);
    endtask

    task automatic set_data(int k, logic [DW-1:0] v);
        bus.iData[k*DW +: DW] = v;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ack"}, bus.oAck, 0);
        chk({tag, "_tmo"}, bus.oTimeout, 0);
        chk({tag, "_res"}, bus.oResult, 0);
        chk({tag, "_en"}, bus.oActEn, 0);
        chk({tag, "_data"}, bus.oActData, 0);
        chk({tag, "_busy"}, bus.oBusy, 0);
    endtask

    initial begin
        bus.iReq  = '0;
        bus.iData = '0;
        rst = 1'b1;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Single request: 100 -> 7, ptr ends at 2
        act_lat = 5;
        set_data(1, 16'd100);
        expect_op(1, 16'd100, 1'b0);
        bus.iReq = 4'b0010;
        drain(40);
        bus.iReq = '0;
        step();
        step();
        chk("idle_busy", bus.oBusy, 0);

        // ptr=2 picks 2 before 0; 2 still asserted gets lowest priority
        act_lat = 2;
        set_data(0, 16'd11);
        set_data(2, 16'd222);
        expect_op(2, 16'd222, 1'b0);
        expect_op(0, 16'd11, 1'b0);
        bus.iReq = 4'b0101;
        drain(60);
        bus.iReq = '0;
        step();
        step();

        // Contention from ptr=0
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        act_lat = 1;
        for (int k = 0; k < NREQ; k++) set_data(k, DW'(1000 + 37 * k));
        for (int k = 0; k < 5; k++) expect_op(k % NREQ, DW'(1000 + 37 * (k % NREQ)), 1'b0);
        bus.iReq = '1;
        drain(100);
        bus.iReq = '0;
        step();
        step();

        // Stale complete: ack only after the fresh rising edge
        act_lat = 3;
        set_data(2, 16'd4321);
        expect_op(2, 16'd4321, 1'b0);
        bus.iReq = 4'b0100;
        drain(40);
        bus.iReq = '0;
        step();
        step();

        // Timeout with complete stuck low
        act_stuck = 1'b1;
        set_data(0, 16'd77);
        expect_op(0, 16'd77, 1'b1);
        bus.iReq = 4'b0001;
        drain(40);
        bus.iReq  = '0;
        act_stuck = 1'b0;
        step();
        step();

        // Reset in WAIT: grant 3 from ptr=1, then 0 after reset
        act_lat = 6;
        set_data(3, 16'd3333);
        set_data(0, 16'd55);
        en_q.push_back(16'd3333);
        bus.iReq = 4'b1001;
        wait_grant(20);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk_zero("midrst");
        rst = 1'b0;
        expect_op(0, 16'd55, 1'b0);
        expect_op(3, 16'd3333, 1'b0);
        drain(80);
        bus.iReq = '0;
        step();
        step();

        // Request and operand change after grant
        act_lat = 4;
        set_data(1, 16'd500);
        expect_op(1, 16'd500, 1'b0);
        bus.iReq = 4'b0010;
        wait_grant(20);
        bus.iReq = '0;
        set_data(1, 16'd999);
        drain(40);
        repeat (4) step();

        chk("no_pending", exp_q.size() + en_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
